// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/response channel into the data-memory arbiter.
// Signals: req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata (request);
//          resp_valid, resp_rdata, resp_err (single-cycle response, no backpressure).
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer sharing one synchronous-read data memory port.
// Ports: clk, rst (asynchronous, active-high);
//        r0, r1       requester channels (dmem_arbiter_if.slave);
//        mem_read_en, mem_write_en, load_type, store_type, ram_address, mem_wdata to the memory;
//        mem_rdata    from the memory, valid the cycle after mem_read_en.
// Build option: define DMEM_RR_ARB_EN for round-robin arbitration; otherwise port 0 wins ties.
module dmem_arbiter #(
    parameter int ADDR_BITS = 12
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave r0,
    dmem_arbiter_if.slave r1,
    output logic          mem_read_en,
    output logic          mem_write_en,
    output logic [2:0]    load_type,
    output logic [2:0]    store_type,
    output logic [31:0]   ram_address,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      state, state_nx;
    logic        gnt, accept, legal, f3_ok, align_ok, idle, issue, resp;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr, sel_wdata;
    logic        port_q, we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    // ready is masked during reset so no handshake is advertised while state is held
    assign idle  = state == IDLE && !rst;
    assign issue = state == ISSUE;
    assign resp  = state == RESP;
`ifdef DMEM_RR_ARB_EN
    // prio_q names the port that wins the next tie; it flips to the other port on every accept
    logic prio_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            prio_q <= 1'b0;
        else if (accept)
            prio_q <= !gnt;
    assign gnt = (r0.req_valid && r1.req_valid) ? prio_q : !r0.req_valid;
`else
    assign gnt = !r0.req_valid;
`endif
    assign accept       = idle && (r0.req_valid || r1.req_valid);
    assign r0.req_ready = idle && r0.req_valid && !gnt;
    assign r1.req_ready = idle && r1.req_valid && gnt;
    assign sel_we    = gnt ? r1.req_we     : r0.req_we;
    assign sel_f3    = gnt ? r1.req_funct3 : r0.req_funct3;
    assign sel_addr  = gnt ? r1.req_addr   : r0.req_addr;
    assign sel_wdata = gnt ? r1.req_wdata  : r0.req_wdata;
    // funct3[1] selects word, funct3[0] halfword; codes outside the tables are rejected by f3_ok
    assign f3_ok    = sel_we ? sel_f3 inside {3'b000, 3'b001, 3'b010}
                             : sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign align_ok = sel_f3[1] ? sel_addr[1:0] == 2'b00 : sel_f3[0] ? !sel_addr[0] : 1'b1;
    assign legal    = f3_ok && align_ok && sel_addr[31:ADDR_BITS] == '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (legal ? ISSUE : RESP) : IDLE;
            ISSUE:   state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            port_q  <= gnt;
            we_q    <= sel_we;
            err_q   <= !legal;
            f3_q    <= sel_f3;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    // memory side depends only on state and latches
    assign mem_read_en  = issue && !we_q;
    assign mem_write_en = issue && we_q;
    assign load_type    = mem_read_en ? f3_q : 3'b0;
    assign store_type   = mem_write_en ? f3_q : 3'b0;
    assign ram_address  = issue ? addr_q : '0;
    assign mem_wdata    = mem_write_en ? wdata_q : '0;
    assign r0.resp_valid = resp && !port_q;
    assign r1.resp_valid = resp && port_q;
    assign r0.resp_err   = r0.resp_valid && err_q;
    assign r1.resp_err   = r1.resp_valid && err_q;
    assign r0.resp_rdata = (r0.resp_valid && !err_q && !we_q) ? mem_rdata : '0;
    assign r1.resp_rdata = (r1.resp_valid && !err_q && !we_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a byte-array memory and reference model.
module tb_dmem_arbiter;
    typedef logic [7:0] bytes_t [4096];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  load_type, store_type;
    logic [31:0] ram_address, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    bytes_t      mem = '{default: 8'h00};
    bytes_t      ref_mem = '{default: 8'h00};
    int          nvec = 0;
    int          nerr = 0;
    dmem_arbiter_if i0();
    dmem_arbiter_if i1();
    dmem_arbiter #(.ADDR_BITS(12)) dut (
        .clk(clk), .rst(rst), .r0(i0), .r1(i1),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .load_type(load_type), .store_type(store_type),
        .ram_address(ram_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    function automatic int sz(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction
    function automatic logic [31:0] load_val(input bytes_t m, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = sz(f3);
        for (int k = 0; k < n; k++) v[8*k +: 8] = m[(a + 32'(k)) % 4096];
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction
    // memory: writes bytes by store_type, registers the typed load result on the enable edge
    always @(posedge clk) begin
        if (mem_write_en)
            for (int k = 0; k < sz(store_type); k++) mem[(ram_address + 32'(k)) % 4096] <= mem_wdata[8*k +: 8];
        if (mem_read_en)
            mem_rdata <= load_val(mem, load_type, ram_address);
    end
    function automatic bit legal_ref(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit known;
        known = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return known && a < 32'd4096 && (a % sz(f3)) == 0;
    endfunction
    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        for (int k = 0; k < sz(f3); k++) ref_mem[(a + 32'(k)) % 4096] = d[8*k +: 8];
    endtask
    function automatic logic ready_of(input int p);
        return p == 1 ? i1.req_ready : i0.req_ready;
    endfunction
    function automatic logic [33:0] resp_of(input int p);
        return p == 1 ? {i1.resp_valid, i1.resp_err, i1.resp_rdata} : {i0.resp_valid, i0.resp_err, i0.resp_rdata};
    endfunction
    function automatic logic [141:0] all_out();
        return {i0.req_ready, i1.req_ready, i0.resp_valid, i1.resp_valid, i0.resp_err, i1.resp_err,
                i0.resp_rdata, i1.resp_rdata, mem_read_en, mem_write_en, load_type, store_type,
                ram_address, mem_wdata};
    endfunction
    task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 1) begin
            i1.req_valid = v; i1.req_we = we; i1.req_funct3 = f3; i1.req_addr = a; i1.req_wdata = d;
        end else begin
            i0.req_valid = v; i0.req_we = we; i0.req_funct3 = f3; i0.req_addr = a; i0.req_wdata = d;
        end
    endtask
    // one transaction on port p; checks acceptance, the ISSUE cycle, response timing and value
    task automatic txn(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        logic [31:0] exp;
        int n;
        ok = legal_ref(we, f3, a);
        exp = (ok && !we) ? load_val(ref_mem, f3, a) : 32'h0;
        @(negedge clk);
        drive(p, 1'b1, we, f3, a, d);
        #1;
        n = 0;
        while (!ready_of(p) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        nvec++;
        if ({ready_of(p), ready_of(1 - p)} !== 2'b10) begin
            nerr++;
            $display("FAIL accept p%0d: ready=%b other_ready=%b, required 1/0", p, ready_of(p), ready_of(1 - p));
            drive(p, 1'b0, we, f3, a, d);
            return;
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, we, f3, a, d);
        @(negedge clk);
        if (ok) begin
            nvec++;
            if ({mem_write_en, mem_read_en, store_type, load_type, ram_address, resp_of(p), resp_of(1 - p)}
                !== {we, !we, we ? f3 : 3'b0, we ? 3'b0 : f3, a, 34'h0, 34'h0}) begin
                nerr++;
                $display("FAIL issue p%0d we=%b f3=%0d a=%h: we/re=%b%b st=%0d lt=%0d addr=%h, required %b%b %0d %0d %h",
                         p, we, f3, a, mem_write_en, mem_read_en, store_type, load_type, ram_address,
                         we, !we, we ? f3 : 3'b0, we ? 3'b0 : f3, a);
            end
            if (we) begin
                nvec++;
                if (mem_wdata !== d) begin
                    nerr++;
                    $display("FAIL wdata p%0d: got %h, required %h", p, mem_wdata, d);
                end
                ref_store(a, f3, d);
            end
            @(negedge clk);
        end
        nvec++;
        if ({resp_of(p), resp_of(1 - p), mem_read_en, mem_write_en} !== {1'b1, !ok, exp, 34'h0, 2'b00}) begin
            nerr++;
            $display("FAIL resp p%0d we=%b f3=%0d a=%h: v/err/rdata=%b/%b/%h other=%h en=%b%b, required 1/%b/%h",
                     p, we, f3, a, resp_of(p)[33], resp_of(p)[32], resp_of(p)[31:0], resp_of(1 - p),
                     mem_read_en, mem_write_en, !ok, exp);
        end
        @(negedge clk);
        nvec++;
        if ({i0.resp_valid, i1.resp_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL resp_single p%0d: resp_valid=%b%b, required 00", p, i0.resp_valid, i1.resp_valid);
        end
    endtask
    task automatic test_reset();
        drive(0, $urandom_range(0, 1), 1'b0, 3'b010, $urandom, $urandom);
        drive(1, $urandom_range(0, 1), 1'b1, 3'b010, $urandom, $urandom);
        #1;
        nvec++;
        if (all_out() !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h, required 0", all_out());
        end
        drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (all_out() !== '0) begin
            nerr++;
            $display("FAIL idle_outputs: got %h, required 0", all_out());
        end
    endtask
    task automatic test_store_load();
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
        txn(1, 1'b1, 3'b010, 32'h10, 32'h80FF7F01);
        txn(1, 1'b0, 3'b000, 32'h13, 32'h0);
        txn(1, 1'b0, 3'b100, 32'h13, 32'h0);
        txn(1, 1'b0, 3'b101, 32'h12, 32'h0);
    endtask
    task automatic test_errors();
        txn(0, 1'b0, 3'b010, 32'h06, 32'h0);
        txn(0, 1'b1, 3'b001, 32'h05, 32'h1234);
        txn(0, 1'b0, 3'b011, 32'h08, 32'h0);
        txn(0, 1'b0, 3'b010, 32'h1000, 32'h0);
    endtask
    task automatic test_back_to_back();
        int exp_g, prio, n;
        logic [31:0] exp;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prio = 0;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        for (int t = 0; t < 4; t++) begin
            #1;
            n = 0;
            while (!(i0.req_ready || i1.req_ready) && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
`ifdef DMEM_RR_ARB_EN
            exp_g = prio;
            prio = 1 - prio;
`else
            exp_g = prio;
`endif
            nvec++;
            if ({i0.req_ready, i1.req_ready} !== (exp_g == 1 ? 2'b01 : 2'b10)) begin
                nerr++;
                $display("FAIL grant #%0d: ready0/1=%b%b, required port %0d", t, i0.req_ready, i1.req_ready, exp_g);
            end
            exp = load_val(ref_mem, 3'b010, exp_g == 1 ? 32'h20 : 32'h10);
            @(negedge clk);
            @(negedge clk);
            nvec++;
            if ({resp_of(exp_g), resp_of(1 - exp_g)} !== {2'b10, exp, 34'h0}) begin
                nerr++;
                $display("FAIL grant_resp #%0d: port%0d resp=%h other=%h, required 1/0/%h", t, exp_g,
                         resp_of(exp_g), resp_of(1 - exp_g), exp);
            end
        end
        drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask
    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        n = 0;
        while (!i1.req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        nvec++;
        if (mem_read_en !== 1'b1) begin
            nerr++;
            $display("FAIL mid_issue: mem_read_en=%b, required 1", mem_read_en);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (all_out() !== '0) begin
            nerr++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_out());
        end
        drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            nvec++;
            if ({i0.resp_valid, i1.resp_valid, mem_read_en, mem_write_en} !== 4'b0) begin
                nerr++;
                $display("FAIL post_reset c%0d: resp_valid=%b%b en=%b%b, required 0", c,
                         i0.resp_valid, i1.resp_valid, mem_read_en, mem_write_en);
            end
            @(negedge clk);
        end
        drive(0, 1'b1, 1'b1, 3'b010, 32'h44, 32'hA5A5_5A5A);
        #1;
        nvec++;
        if (i0.req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL post_reset_ready: ready0=%b, required 1", i0.req_ready);
        end
        drive(0, 1'b0, 1'b1, 3'b010, 32'h44, 32'hA5A5_5A5A);
        txn(0, 1'b1, 3'b010, 32'h44, 32'hA5A5_5A5A);
        txn(0, 1'b0, 3'b010, 32'h44, 32'h0);
    endtask
    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
